// File: rtl/act_requant_unit_pkg.sv
`default_nettype none
// ============================================================================
// act_requant_unit_pkg : shared array constants and FSM state encoding
// Rev 1.0
// ============================================================================
package act_requant_unit_pkg;

    localparam int SA_LANES     = 16;
    localparam int SA_ACC_BITS  = 20;
    localparam int SA_OUT_BITS  = 8;
    localparam int SA_ADDR_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/act_requant_unit_if.sv
`default_nettype none
// ============================================================================
// act_requant_unit_if : accumulator read port + unified-buffer write port
// Rev 1.0
// ============================================================================
interface act_requant_unit_if
    import act_requant_unit_pkg::*;
#(
    parameter int LANES     = SA_LANES,
    parameter int ACC_BITS  = SA_ACC_BITS,
    parameter int OUT_BITS  = SA_OUT_BITS,
    parameter int ADDR_BITS = SA_ADDR_BITS
) ();

    logic                      acc_rd_en;
    logic [ADDR_BITS-1:0]      acc_rd_addr;
    logic [LANES*ACC_BITS-1:0] acc_rd_data;
    logic                      ub_wr_en;
    logic                      ub_wr_ready;
    logic [ADDR_BITS-1:0]      ub_wr_addr;
    logic [LANES*OUT_BITS-1:0] ub_wr_data;

    modport master (
        output acc_rd_en, acc_rd_addr,
        input  acc_rd_data,
        output ub_wr_en, ub_wr_addr, ub_wr_data,
        input  ub_wr_ready
    );

    modport slave (
        input  acc_rd_en, acc_rd_addr,
        output acc_rd_data,
        input  ub_wr_en, ub_wr_addr, ub_wr_data,
        output ub_wr_ready
    );

endinterface
`default_nettype wire

// File: rtl/act_requant_unit_requant_lane.sv
`default_nettype none
// ============================================================================
// requant_lane : one-lane ReLU / round / shift / saturate (combinational)
// Build option: ACT_ROUNDING_EN selects round-half-up instead of floor. Rev 1.0
// ============================================================================
module requant_lane #(
    parameter int ACC_BITS = 20,
    parameter int OUT_BITS = 8
) (
    input  logic signed [ACC_BITS-1:0] acc,
    input  logic        [3:0]          shift,
    input  logic                       relu,
    output logic signed [OUT_BITS-1:0] q
);

    localparam logic signed [ACC_BITS:0] c_max = (ACC_BITS+1)'(2**(OUT_BITS-1) - 1);
    localparam logic signed [ACC_BITS:0] c_min = ~c_max;
`ifdef ACT_ROUNDING_EN
    localparam logic signed [ACC_BITS:0] c_one = (ACC_BITS+1)'(1);
`endif

    logic signed [ACC_BITS:0] w_ext;
    logic signed [ACC_BITS:0] w_relu;
    logic signed [ACC_BITS:0] w_rnd;
    logic signed [ACC_BITS:0] w_shf;

    // One guard bit keeps the rounding add from overflowing the accumulator range.
    always_comb begin
        w_ext  = {acc[ACC_BITS-1], acc};
        w_relu = (relu && w_ext[ACC_BITS]) ? '0 : w_ext;
        w_rnd  = w_relu;
`ifdef ACT_ROUNDING_EN
        if (shift != 4'd0) begin
            w_rnd = w_relu + (c_one << (shift - 4'd1));
        end
`endif
        w_shf = w_rnd >>> shift;
        if (w_shf > c_max) begin
            q = c_max[OUT_BITS-1:0];
        end else if (w_shf < c_min) begin
            q = c_min[OUT_BITS-1:0];
        end else begin
            q = w_shf[OUT_BITS-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/act_requant_unit.sv
`default_nettype none
// ============================================================================
// act_requant_unit : streams accumulator rows through requant lanes into UB
// Build option: ACT_ROUNDING_EN (rounding mode, see requant_lane). Rev 1.0
// ============================================================================
module act_requant_unit
    import act_requant_unit_pkg::*;
#(
    parameter int LANES     = SA_LANES,
    parameter int ACC_BITS  = SA_ACC_BITS,
    parameter int OUT_BITS  = SA_OUT_BITS,
    parameter int ADDR_BITS = SA_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] cfg_src_base,
    input  logic [ADDR_BITS-1:0] cfg_dst_base,
    input  logic [ADDR_BITS-1:0] cfg_len,
    input  logic [3:0]           cfg_shift,
    input  logic                 cfg_relu,
    output logic                 busy,
    output logic                 done,
    act_requant_unit_if.master   bus
);

    localparam logic [ADDR_BITS-1:0] c_addr_one = ADDR_BITS'(1);

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDR_BITS-1:0]      r_src;
    logic [ADDR_BITS-1:0]      r_dst;
    logic [ADDR_BITS-1:0]      r_len;
    logic [3:0]                r_shift;
    logic                      r_relu;
    logic [ADDR_BITS-1:0]      r_rd_cnt;
    logic [ADDR_BITS-1:0]      r_wr_cnt;
    logic                      r_inflight;
    logic [1:0]                r_count;
    logic [LANES*OUT_BITS-1:0] r_buf0;
    logic [LANES*OUT_BITS-1:0] r_buf1;
    logic [LANES*OUT_BITS-1:0] w_row;
    logic [ADDR_BITS-1:0]      w_len_m1;
    logic                      w_pop;
    logic                      w_room;
    logic                      w_rd_en;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane #(
            .ACC_BITS (ACC_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .acc   (bus.acc_rd_data[ACC_BITS*g +: ACC_BITS]),
            .shift (r_shift),
            .relu  (r_relu),
            .q     (w_row[OUT_BITS*g +: OUT_BITS])
        );
    end

    assign w_len_m1 = r_len - c_addr_one;
    assign w_pop    = (r_count != 2'd0) && bus.ub_wr_ready;
    // A read is allowed only if the skid buffer can absorb it after the
    // row already in flight lands, even if the writer stalls from now on.
    assign w_room   = (({1'b0, r_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
    assign w_rd_en  = (r_state == ST_RUN) && w_room;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_rd_en && (r_rd_cnt == w_len_m1)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && (r_wr_cnt == w_len_m1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if ((r_state == ST_IDLE) && start) begin
                r_src    <= cfg_src_base;
                r_dst    <= cfg_dst_base;
                r_len    <= cfg_len;
                r_shift  <= cfg_shift;
                r_relu   <= cfg_relu;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + c_addr_one;
                end
                if (w_pop) begin
                    r_wr_cnt <= r_wr_cnt + c_addr_one;
                end
            end
        end
    end

    // Two-entry skid FIFO; entry 0 is always the row presented to the UB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else if (r_inflight && w_pop) begin
            if (r_count == 2'd1) begin
                r_buf0 <= w_row;
            end else begin
                r_buf0 <= r_buf1;
                r_buf1 <= w_row;
            end
        end else if (w_pop) begin
            r_buf0  <= r_buf1;
            r_count <= r_count - 2'd1;
        end else if (r_inflight) begin
            if (r_count == 2'd0) begin
                r_buf0 <= w_row;
            end else begin
                r_buf1 <= w_row;
            end
            r_count <= r_count + 2'd1;
        end
    end

    assign bus.acc_rd_en   = w_rd_en;
    assign bus.acc_rd_addr = r_src + r_rd_cnt;
    assign bus.ub_wr_en    = (r_count != 2'd0);
    assign bus.ub_wr_addr  = r_dst + r_wr_cnt;
    assign bus.ub_wr_data  = r_buf0;
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_act_requant_unit.sv
`default_nettype none
// ============================================================================
// tb_act_requant_unit : randomized self-checking bench with arithmetic model
// Rev 1.0
// ============================================================================
module tb_act_requant_unit;
    import act_requant_unit_pkg::*;

    localparam int LANES    = SA_LANES;
    localparam int ACC_BITS = SA_ACC_BITS;
    localparam int OUT_BITS = SA_OUT_BITS;
    localparam int RW       = LANES * ACC_BITS;
    localparam int OW       = LANES * OUT_BITS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] cfg_src_base, cfg_dst_base, cfg_len;
    logic [3:0] cfg_shift;
    logic       cfg_relu;
    logic       busy, done;

    act_requant_unit_if bus_if ();

    act_requant_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_len      (cfg_len),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .busy         (busy),
        .done         (done),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int start_cyc;

    logic [RW-1:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator memory: row appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (!reset_n) bus_if.acc_rd_data <= '0;
        else if (bus_if.acc_rd_en) bus_if.acc_rd_data <= mem[bus_if.acc_rd_addr];
    end

    int            rd_q[$];
    int            hs_addr_q[$];
    logic [OW-1:0] hs_data_q[$];
    int            hs_cyc_q[$];
    int            first_wen, done_cnt, done_cyc, stall_viol;
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_addr;
    logic [OW-1:0] prev_data;

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall && (!bus_if.ub_wr_en || bus_if.ub_wr_addr !== prev_addr
                               || bus_if.ub_wr_data !== prev_data)) stall_viol++;
            prev_stall = bus_if.ub_wr_en && !bus_if.ub_wr_ready;
            prev_addr  = bus_if.ub_wr_addr;
            prev_data  = bus_if.ub_wr_data;
            if (bus_if.acc_rd_en) rd_q.push_back(int'(bus_if.acc_rd_addr));
            if (bus_if.ub_wr_en && bus_if.ub_wr_ready) begin
                hs_addr_q.push_back(int'(bus_if.ub_wr_addr));
                hs_data_q.push_back(bus_if.ub_wr_data);
                hs_cyc_q.push_back(cyc);
            end
            if (bus_if.ub_wr_en && first_wen < 0) first_wen = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_lane(int a, int sh, bit relu);
        int v;
        v = a;
        if (relu && v < 0) v = 0;
`ifdef ACT_ROUNDING_EN
        if (sh > 0) v = v + (1 << (sh - 1));
`endif
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic logic [OW-1:0] ref_row(logic [RW-1:0] r, int sh, bit relu);
        logic [OW-1:0] o;
        int a;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            a = $signed(r[ACC_BITS*i +: ACC_BITS]);
            o[OUT_BITS*i +: OUT_BITS] = OUT_BITS'(ref_lane(a, sh, relu));
        end
        return o;
    endfunction

    task automatic set_lane(int row, int lane, int val);
        mem[row][ACC_BITS*lane +: ACC_BITS] = ACC_BITS'(val);
    endtask

    task automatic rand_row(int row);
        for (int i = 0; i < LANES; i++) set_lane(row, i, int'($urandom) >>> 12);
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 3 cycles after 2nd handshake
    task automatic run_job(int src, int dst, int len, int sh, bit relu, int mode, bit poke);
        int  k;
        int  bp_left;
        bit  bp_started;
        @(posedge clk); #1;
        rd_q.delete(); hs_addr_q.delete(); hs_data_q.delete(); hs_cyc_q.delete();
        first_wen = -1; done_cnt = 0; done_cyc = -1; stall_viol = 0;
        cfg_src_base = 8'(src); cfg_dst_base = 8'(dst); cfg_len = 8'(len);
        cfg_shift = 4'(sh); cfg_relu = relu;
        bus_if.ub_wr_ready = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        k = 0; bp_left = 0; bp_started = 0;
        while (done_cnt == 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
            start = poke && (k == 2 || k == 4);
            cfg_src_base = 8'($urandom); cfg_dst_base = 8'($urandom);
            cfg_len = 8'($urandom); cfg_shift = 4'($urandom); cfg_relu = 1'($urandom);
            case (mode)
                0: bus_if.ub_wr_ready = 1'b1;
                1: bus_if.ub_wr_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bp_left > 0) begin
                        bus_if.ub_wr_ready = 1'b0;
                        bp_left--;
                    end else if (!bp_started && hs_addr_q.size() == 2) begin
                        bp_started = 1;
                        bus_if.ub_wr_ready = 1'b0;
                        bp_left = 2;
                    end else begin
                        bus_if.ub_wr_ready = 1'b1;
                    end
                end
            endcase
        end
        n_total++;
        if (done_cnt == 0) $display("FAIL job_timeout: no done after %0d cycles (required done)", k);
        else n_pass++;
        start = 1'b0;
        bus_if.ub_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_total++; if (bus_if.acc_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", bus_if.acc_rd_en); else n_pass++;
        n_total++; if (bus_if.acc_rd_addr !== 8'h00) $display("FAIL rst_rd_addr: got %h want 00", bus_if.acc_rd_addr); else n_pass++;
        n_total++; if (bus_if.ub_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", bus_if.ub_wr_en); else n_pass++;
        n_total++; if (bus_if.ub_wr_addr !== 8'h00) $display("FAIL rst_wr_addr: got %h want 00", bus_if.ub_wr_addr); else n_pass++;
        n_total++; if (bus_if.ub_wr_data !== '0) $display("FAIL rst_wr_data: got %h want 0", bus_if.ub_wr_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [OW-1:0] d;
        rand_row(8'h20);
        set_lane(8'h20, 0, 100);
        set_lane(8'h20, 1, -5);
        run_job(8'h20, 8'h10, 1, 0, 0, 0, 0);
        d = hs_data_q[0];
        n_total++; if (hs_addr_q.size() != 1) $display("FAIL basic_count: got %0d want 1", hs_addr_q.size()); else n_pass++;
        n_total++; if (hs_addr_q[0] != 8'h10) $display("FAIL basic_addr: got %h want 10", hs_addr_q[0]); else n_pass++;
        n_total++; if (d[7:0] !== 8'h64) $display("FAIL basic_lane0: got %h want 64", d[7:0]); else n_pass++;
        n_total++; if (d[15:8] !== 8'hFB) $display("FAIL basic_lane1: got %h want fb", d[15:8]); else n_pass++;
        n_total++; if (d !== ref_row(mem[8'h20], 0, 0)) $display("FAIL basic_row: got %h want %h", d, ref_row(mem[8'h20], 0, 0)); else n_pass++;
        n_total++; if (first_wen != start_cyc + 3) $display("FAIL basic_latency: got %0d want %0d", first_wen - start_cyc, 3); else n_pass++;
        n_total++; if (done_cyc != hs_cyc_q[0] + 1) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, hs_cyc_q[0] + 1); else n_pass++;
        n_total++; if (rd_q.size() != 1 || rd_q[0] != 8'h20) $display("FAIL basic_read: got n=%0d a=%h want n=1 a=20", rd_q.size(), rd_q[0]); else n_pass++;
    endtask

    task automatic test_saturation;
        logic [OW-1:0] d;
        rand_row(8'h30);
        set_lane(8'h30, 0, 32'h7FFFF);
        set_lane(8'h30, 1, -524288);
        run_job(8'h30, 8'h31, 1, 4, 0, 0, 0);
        d = hs_data_q[0];
        n_total++; if (d[7:0] !== 8'h7F) $display("FAIL sat_pos: got %h want 7f", d[7:0]); else n_pass++;
        n_total++; if (d[15:8] !== 8'h80) $display("FAIL sat_neg: got %h want 80", d[15:8]); else n_pass++;
        n_total++; if (d !== ref_row(mem[8'h30], 4, 0)) $display("FAIL sat_row: got %h want %h", d, ref_row(mem[8'h30], 4, 0)); else n_pass++;
    endtask

    task automatic test_rounding;
        logic [OW-1:0] d;
        logic [7:0] e0, e1;
`ifdef ACT_ROUNDING_EN
        e0 = 8'd2;  e1 = 8'hFF;
`else
        e0 = 8'd1;  e1 = 8'hFE;
`endif
        rand_row(8'h50);
        set_lane(8'h50, 0, 6);
        set_lane(8'h50, 1, -6);
        run_job(8'h50, 8'h51, 1, 2, 0, 0, 0);
        d = hs_data_q[0];
        n_total++; if (d[7:0] !== e0) $display("FAIL round_pos: got %h want %h", d[7:0], e0); else n_pass++;
        n_total++; if (d[15:8] !== e1) $display("FAIL round_neg: got %h want %h", d[15:8], e1); else n_pass++;
        n_total++; if (d !== ref_row(mem[8'h50], 2, 0)) $display("FAIL round_row: got %h want %h", d, ref_row(mem[8'h50], 2, 0)); else n_pass++;
    endtask

    task automatic test_relu;
        logic [OW-1:0] d;
        rand_row(8'h60);
        set_lane(8'h60, 0, -300);
        set_lane(8'h60, 1, 300);
        run_job(8'h60, 8'h61, 1, 0, 1, 0, 0);
        d = hs_data_q[0];
        n_total++; if (d[7:0] !== 8'h00) $display("FAIL relu_neg: got %h want 00", d[7:0]); else n_pass++;
        n_total++; if (d[15:8] !== 8'h7F) $display("FAIL relu_pos: got %h want 7f", d[15:8]); else n_pass++;
        n_total++; if (d !== ref_row(mem[8'h60], 0, 1)) $display("FAIL relu_row: got %h want %h", d, ref_row(mem[8'h60], 0, 1)); else n_pass++;
    endtask

    task automatic test_backpressure;
        int sh;
        sh = $urandom_range(0, 6);
        run_job(8'h40, 8'h80, 4, sh, 0, 2, 0);
        n_total++; if (hs_addr_q.size() != 4) $display("FAIL bp_count: got %0d want 4", hs_addr_q.size()); else n_pass++;
        for (int j = 0; j < hs_addr_q.size(); j++) begin
            n_total++; if (hs_addr_q[j] != 8'h80 + j) $display("FAIL bp_addr[%0d]: got %h want %h", j, hs_addr_q[j], 8'h80 + j); else n_pass++;
            n_total++; if (hs_data_q[j] !== ref_row(mem[8'h40 + j], sh, 0)) $display("FAIL bp_data[%0d]: got %h want %h", j, hs_data_q[j], ref_row(mem[8'h40 + j], sh, 0)); else n_pass++;
        end
        n_total++; if (hs_cyc_q[2] - hs_cyc_q[1] != 4) $display("FAIL bp_gap: got %0d want 4", hs_cyc_q[2] - hs_cyc_q[1]); else n_pass++;
        n_total++; if (stall_viol != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_viol); else n_pass++;
    endtask

    task automatic test_wrap;
        int exp_rd[3] = '{8'hFE, 8'hFF, 8'h00};
        int exp_wr[3] = '{8'hFF, 8'h00, 8'h01};
        run_job(8'hFE, 8'hFF, 3, 1, 0, 0, 0);
        n_total++; if (rd_q.size() != 3 || hs_addr_q.size() != 3) $display("FAIL wrap_count: got rd=%0d wr=%0d want 3/3", rd_q.size(), hs_addr_q.size()); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            n_total++; if (rd_q[j] != exp_rd[j]) $display("FAIL wrap_rd[%0d]: got %h want %h", j, rd_q[j], exp_rd[j]); else n_pass++;
            n_total++; if (hs_addr_q[j] != exp_wr[j]) $display("FAIL wrap_wr[%0d]: got %h want %h", j, hs_addr_q[j], exp_wr[j]); else n_pass++;
            n_total++; if (hs_data_q[j] !== ref_row(mem[exp_rd[j]], 1, 0)) $display("FAIL wrap_data[%0d]: got %h want %h", j, hs_data_q[j], ref_row(mem[exp_rd[j]], 1, 0)); else n_pass++;
        end
    endtask

    task automatic test_random;
        int src, dst, len, sh;
        bit relu;
        for (int t = 0; t < 6; t++) begin
            src = $urandom_range(0, 255); dst = $urandom_range(0, 255);
            len = $urandom_range(1, 20);  sh = $urandom_range(0, 15);
            relu = 1'($urandom);
            run_job(src, dst, len, sh, relu, 1, 0);
            n_total++; if (hs_addr_q.size() != len || rd_q.size() != len) $display("FAIL rand_count[%0d]: got rd=%0d wr=%0d want %0d", t, rd_q.size(), hs_addr_q.size(), len); else n_pass++;
            for (int j = 0; j < hs_addr_q.size(); j++) begin
                n_total++;
                if (hs_addr_q[j] != ((dst + j) & 255) || rd_q[j] != ((src + j) & 255)
                    || hs_data_q[j] !== ref_row(mem[(src + j) & 255], sh, relu))
                    $display("FAIL rand_row[%0d.%0d]: got a=%h d=%h want a=%h d=%h", t, j, hs_addr_q[j], hs_data_q[j],
                             (dst + j) & 255, ref_row(mem[(src + j) & 255], sh, relu));
                else n_pass++;
            end
            n_total++; if (stall_viol != 0) $display("FAIL rand_stable[%0d]: got %0d want 0", t, stall_viol); else n_pass++;
        end
    endtask

    task automatic test_empty;
        run_job(8'h12, 8'h34, 0, 0, 0, 0, 0);
        n_total++; if (hs_addr_q.size() != 0 || rd_q.size() != 0) $display("FAIL empty_strobes: got rd=%0d wr=%0d want 0/0", rd_q.size(), hs_addr_q.size()); else n_pass++;
        n_total++; if (first_wen != -1) $display("FAIL empty_wr_en: got cycle %0d want never", first_wen); else n_pass++;
        n_total++; if (done_cyc != start_cyc + 1) $display("FAIL empty_done: got %0d want %0d", done_cyc - start_cyc, 1); else n_pass++;
    endtask

    task automatic test_busy_start;
        run_job(8'h70, 8'h90, 5, 0, 0, 0, 1);
        n_total++; if (hs_addr_q.size() != 5) $display("FAIL busy_count: got %0d want 5", hs_addr_q.size()); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL busy_done: got %0d want 1", done_cnt); else n_pass++;
        for (int j = 0; j < hs_addr_q.size(); j++) begin
            n_total++; if (hs_addr_q[j] != 8'h90 + j) $display("FAIL busy_addr[%0d]: got %h want %h", j, hs_addr_q[j], 8'h90 + j); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_midrun;
        int n_hs;
        @(posedge clk); #1;
        hs_addr_q.delete(); done_cnt = 0;
        cfg_src_base = 8'h00; cfg_dst_base = 8'hA0; cfg_len = 8'd8;
        cfg_shift = 4'd0; cfg_relu = 1'b0; bus_if.ub_wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
        n_hs = hs_addr_q.size();
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus_if.acc_rd_en, bus_if.acc_rd_addr, bus_if.ub_wr_en, bus_if.ub_wr_addr, bus_if.ub_wr_data, busy, done} !== '0)
            $display("FAIL mid_outputs: got rd=%b ra=%h we=%b wa=%h wd=%h busy=%b done=%b want all 0",
                     bus_if.acc_rd_en, bus_if.acc_rd_addr, bus_if.ub_wr_en, bus_if.ub_wr_addr, bus_if.ub_wr_data, busy, done);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (hs_addr_q.size() != n_hs) $display("FAIL mid_writes: got %0d want %0d", hs_addr_q.size(), n_hs); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL mid_done: got %0d want 0", done_cnt); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
        bus_if.ub_wr_ready = 1'b1;
        for (int r = 0; r < 256; r++) rand_row(r);
        test_reset;
        test_basic;
        test_saturation;
        test_rounding;
        test_relu;
        test_backpressure;
        test_wrap;
        test_empty;
        test_busy_start;
        test_reset_midrun;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
